spectrum_pix_src: RTL and testbench

Pixel source for the HDMI output path. Answers each `pix_req` from the HDMI timing/pattern stage with one 24-bit RGB pixel in raster order, and renders a 64-bar audio spectrum. Bar heights come from a double-buffered magnitude bank. The audio/FFT side writes the shadow bank, and commits are applied only at frame start, so a frame never tears. Runs entirely in the HDMI pixel clock domain.

---
 rtl/spectrum_pix_src.sv | 160 ++++++++++++++++
 tb/tb_spectrum_pix_src.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_pix_src.sv
// spectrum_pix_src: raster-order pixel source drawing a bar spectrum from a
// double-buffered magnitude bank; bank swaps are deferred to frame start.
module spectrum_pix_src #(
    parameter int unsigned H_ACT = 1920,
    parameter int unsigned V_ACT = 1080,
    parameter int unsigned BINS  = 64,
    parameter int unsigned BAR_W = 30,
    parameter int unsigned MAG_W = 11
) (
    input  logic             pix_clk,
    input  logic             sys_rst,
    input  logic             vs_in,
    input  logic             pix_req,
    output logic [23:0]      pix_data,
    input  logic             bin_wr_en,
    input  logic [5:0]       bin_wr_addr,
    input  logic [MAG_W-1:0] bin_wr_data,
    input  logic             bin_commit,
    output logic             swap_pulse,
    output logic             frame_err
);

    localparam int unsigned X_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int unsigned Y_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int unsigned B_W = (BINS > 1) ? $clog2(BINS) : 1;
    localparam int unsigned S_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [23:0] C_GAP    = 24'h000000;
    localparam logic [23:0] C_GREEN  = 24'h00FF00;
    localparam logic [23:0] C_YELLOW = 24'hFFFF00;
    localparam logic [23:0] C_RED    = 24'hFF0000;
    localparam logic [23:0] C_BG     = 24'h101010;

    logic [X_W-1:0]   x_q, x_cur_c, x_nxt_c;
    logic [Y_W-1:0]   y_q, y_cur_c, y_nxt_c;
    logic [B_W-1:0]   bin_q, bin_cur_c, bin_nxt_c;
    logic [S_W-1:0]   sub_q, sub_cur_c, sub_nxt_c;
    logic             vs_q;
    logic             pending_q;
    logic             fs_c;
    logic             swap_c;
    logic [MAG_W-1:0] shadow_q [BINS];
    logic [MAG_W-1:0] active_q [BINS];
    logic [MAG_W-1:0] mag_c;
    logic [MAG_W-1:0] h_c;
    logic [23:0]      colour_c;

    // Frame-start detect; position is forced to the origin before serving a request
    always_comb begin
        fs_c      = vs_in & ~vs_q;
        swap_c    = fs_c & (pending_q | bin_commit);
        x_cur_c   = fs_c ? '0 : x_q;
        y_cur_c   = fs_c ? '0 : y_q;
        bin_cur_c = fs_c ? '0 : bin_q;
        sub_cur_c = fs_c ? '0 : sub_q;
    end

    // Raster advance with incremental bar/sub-column tracking
    always_comb begin
        x_nxt_c   = x_cur_c;
        y_nxt_c   = y_cur_c;
        bin_nxt_c = bin_cur_c;
        sub_nxt_c = sub_cur_c;
        if (pix_req) begin
            if (x_cur_c == X_W'(H_ACT - 1)) begin
                x_nxt_c   = '0;
                bin_nxt_c = '0;
                sub_nxt_c = '0;
                y_nxt_c   = (y_cur_c == Y_W'(V_ACT - 1)) ? '0 : y_cur_c + Y_W'(1);
            end else begin
                x_nxt_c = x_cur_c + X_W'(1);
                if (sub_cur_c == S_W'(BAR_W - 1)) begin
                    sub_nxt_c = '0;
                    bin_nxt_c = bin_cur_c + B_W'(1);
                end else begin
                    sub_nxt_c = sub_cur_c + S_W'(1);
                end
            end
        end
    end

    // Colour of the pixel at the current position from the active bank
    always_comb begin
        mag_c    = active_q[bin_cur_c];
        if (mag_c > MAG_W'(V_ACT)) begin
            mag_c = MAG_W'(V_ACT);
        end
        h_c      = MAG_W'(V_ACT - 1) - MAG_W'(y_cur_c);
        colour_c = C_BG;
        if (sub_cur_c == S_W'(BAR_W - 1)) begin
            colour_c = C_GAP;
        end else if (h_c < mag_c) begin
            if (h_c < MAG_W'(360)) begin
                colour_c = C_GREEN;
            end else if (h_c < MAG_W'(720)) begin
                colour_c = C_YELLOW;
            end else begin
                colour_c = C_RED;
            end
        end
    end

    // Raster position, sync edge history and status outputs
    always_ff @(posedge pix_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_q        <= '0;
            y_q        <= '0;
            bin_q      <= '0;
            sub_q      <= '0;
            vs_q       <= 1'b0;
            pix_data   <= '0;
            swap_pulse <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            x_q        <= x_nxt_c;
            y_q        <= y_nxt_c;
            bin_q      <= bin_nxt_c;
            sub_q      <= sub_nxt_c;
            vs_q       <= vs_in;
            swap_pulse <= swap_c;
            if (fs_c && ((x_q != '0) || (y_q != '0))) begin
                frame_err <= 1'b1;
            end
            if (pix_req) begin
                pix_data <= colour_c;
            end
        end
    end

    // Commit request latch, cleared by the frame-start swap
    always_ff @(posedge pix_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pending_q <= 1'b0;
        end else if (swap_c) begin
            pending_q <= 1'b0;
        end else if (bin_commit) begin
            pending_q <= 1'b1;
        end
    end

    // Shadow bank writes and whole-bank publish to the active bank
    always_ff @(posedge pix_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < int'(BINS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(BINS); i++) begin
                if (swap_c) begin
                    active_q[i] <= shadow_q[i];
                end
                if (bin_wr_en && (bin_wr_addr == 6'(i))) begin
                    shadow_q[i] <= bin_wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_spectrum_pix_src.sv
// Bench for spectrum_pix_src with a narrow raster (4 bars x 3 px) at full height.
module tb_spectrum_pix_src;

    localparam int H  = 12;
    localparam int V  = 1080;
    localparam int NB = 4;
    localparam int BW = 3;
    localparam int MW = 11;

    logic          pix_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          vs_in = 1'b0;
    logic          pix_req = 1'b0;
    logic [23:0]   pix_data;
    logic          bin_wr_en = 1'b0;
    logic [5:0]    bin_wr_addr = '0;
    logic [MW-1:0] bin_wr_data = '0;
    logic          bin_commit = 1'b0;
    logic          swap_pulse;
    logic          frame_err;

    always #5 pix_clk = ~pix_clk;

    spectrum_pix_src #(
        .H_ACT(H), .V_ACT(V), .BINS(NB), .BAR_W(BW), .MAG_W(MW)
    ) dut (
        .pix_clk(pix_clk), .sys_rst(sys_rst), .vs_in(vs_in), .pix_req(pix_req),
        .pix_data(pix_data), .bin_wr_en(bin_wr_en), .bin_wr_addr(bin_wr_addr),
        .bin_wr_data(bin_wr_data), .bin_commit(bin_commit),
        .swap_pulse(swap_pulse), .frame_err(frame_err)
    );

    typedef struct { int x; int y; logic [23:0] pix; } exp_t;
    typedef struct { int x; int y; logic [23:0] exp; } spot_t;

    exp_t          sbq[$];
    spot_t         spots[13];
    int            checks = 0;
    int            errors = 0;

    int            mx, my;
    logic          mvsq, mpend, merr, mswap;
    logic [MW-1:0] msh[NB];
    logic [MW-1:0] mac[NB];
    logic [23:0]   last_exp;
    bit            cap_en = 1'b0;
    logic [23:0]   cap[V][H];

    function automatic logic [23:0] ref_pix(int x, int y);
        int b = x / BW;
        int s = x % BW;
        int h = V - 1 - y;
        int m = int'(mac[b]);
        if (m > V) m = V;
        if (s == BW - 1) return 24'h000000;
        if (h < m && h < 360) return 24'h00FF00;
        if (h < m && h < 720) return 24'hFFFF00;
        if (h < m) return 24'hFF0000;
        return 24'h101010;
    endfunction

    task automatic chk(string name, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mx = 0; my = 0; mvsq = 0; mpend = 0; merr = 0; mswap = 0;
        for (int i = 0; i < NB; i++) begin
            msh[i] = '0;
            mac[i] = '0;
        end
        sbq.delete();
        last_exp = '0;
    endtask

    // One clock: update the model from current inputs, then compare after the edge
    task automatic tick();
        exp_t e;
        logic fs;
        fs = vs_in && !mvsq;
        if (fs) begin
            if (mx != 0 || my != 0) merr = 1'b1;
            mx = 0;
            my = 0;
        end
        if (pix_req) begin
            e.x = mx; e.y = my; e.pix = ref_pix(mx, my);
            sbq.push_back(e);
            if (mx == H - 1) begin
                mx = 0;
                my = (my == V - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        mswap = fs && (mpend || bin_commit);
        if (mswap) for (int i = 0; i < NB; i++) mac[i] = msh[i];
        if (bin_wr_en && int'(bin_wr_addr) < NB) msh[bin_wr_addr] = bin_wr_data;
        mpend = mswap ? 1'b0 : (bin_commit ? 1'b1 : mpend);
        mvsq = vs_in;
        @(posedge pix_clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("pix(%0d,%0d)", e.x, e.y), pix_data, e.pix);
            last_exp = e.pix;
            if (cap_en) cap[e.y][e.x] = pix_data;
        end else begin
            chk("hold", pix_data, last_exp);
        end
        chk("swap_pulse", 24'(swap_pulse), 24'(mswap));
        chk("frame_err", 24'(frame_err), 24'(merr));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic req_n(int n);
        pix_req = 1'b1;
        for (int i = 0; i < n; i++) tick();
        pix_req = 1'b0;
    endtask

    task automatic vs_edge();
        vs_in = 1'b1; tick();
        vs_in = 1'b0; tick();
    endtask

    task automatic wr(int addr, int data, logic commit);
        bin_wr_en = 1'b1; bin_wr_addr = 6'(addr); bin_wr_data = MW'(data);
        bin_commit = commit;
        tick();
        bin_wr_en = 1'b0; bin_commit = 1'b0;
    endtask

    task automatic do_reset();
        vs_in = 0; pix_req = 0; bin_wr_en = 0; bin_commit = 0;
        sys_rst = 1'b1;
        #2;
        chk("rst_pix", pix_data, 24'h0);
        chk("rst_swap", 24'(swap_pulse), 24'h0);
        chk("rst_err", 24'(frame_err), 24'h0);
        repeat (2) @(posedge pix_clk);
        @(negedge pix_clk);
        sys_rst = 1'b0;
        model_clear();
    endtask

    initial begin
        spots[0]  = '{0, 1079, 24'h00FF00};
        spots[1]  = '{0, 980,  24'h00FF00};
        spots[2]  = '{0, 979,  24'h101010};
        spots[3]  = '{2, 1079, 24'h000000};
        spots[4]  = '{3, 720,  24'h00FF00};
        spots[5]  = '{4, 719,  24'hFFFF00};
        spots[6]  = '{3, 580,  24'hFFFF00};
        spots[7]  = '{3, 579,  24'h101010};
        spots[8]  = '{9, 0,    24'hFF0000};
        spots[9]  = '{10, 359, 24'hFF0000};
        spots[10] = '{9, 360,  24'hFFFF00};
        spots[11] = '{6, 1079, 24'h101010};
        spots[12] = '{11, 0,   24'h000000};

        #1;
        do_reset();

        // Empty banks: whole frame is background with gap columns
        req_n(H * V);
        vs_edge();

        // Load bars, including an out-of-range address that must be dropped
        wr(0, 100, 1'b0);
        wr(1, 500, 1'b0);
        wr(9, 777, 1'b0);
        wr(3, 2000, 1'b0);
        bin_commit = 1'b1; tick(); bin_commit = 1'b0;
        idle(2);
        vs_edge();
        cap_en = 1'b1;
        req_n(H * V);
        for (int i = 0; i < 13; i++)
            chk($sformatf("spot%0d", i), cap[spots[i].y][spots[i].x], spots[i].exp);

        // Uncommitted write survives two frame starts unpublished
        wr(2, 300, 1'b0);
        vs_edge();
        idle(3);
        vs_edge();
        req_n(H * V);
        chk("bin2_unpub", cap[1079][6], 24'h101010);

        // Write+commit together, then a write landing in the swap cycle
        wr(0, 50, 1'b1);
        idle(2);
        vs_in = 1'b1;
        wr(1, 50, 1'b0);
        vs_in = 1'b0;
        tick();
        req_n(H * V);
        cap_en = 1'b0;
        chk("bin2_pub", cap[1079][6], 24'h00FF00);
        chk("bin0_top", cap[1029][0], 24'h101010);
        chk("bin0_in", cap[1030][0], 24'h00FF00);
        chk("bin1_kept", cap[580][3], 24'hFFFF00);

        // Frame start together with a request, then an early frame start
        bin_commit = 1'b1; tick(); bin_commit = 1'b0;
        vs_in = 1'b1; pix_req = 1'b1; tick();
        vs_in = 1'b0;
        req_n(999);
        vs_in = 1'b1; tick(); vs_in = 1'b0;
        chk("err_set", 24'(frame_err), 24'h1);
        pix_req = 1'b1; tick(); pix_req = 1'b0;
        chk("origin", pix_data, 24'h101010);
        req_n(12);
        idle(3);
        chk("err_sticky", 24'(frame_err), 24'h1);

        // Mid-line reset clears banks, status and raster
        req_n(5);
        do_reset();
        req_n(H * V);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
